// File: rtl/vga_pkg.sv
// Shared VGA constants and the arbiter FSM state encoding.
// Used by vga_mem_arbiter (optional VGA_ARB_STATS_EN stall counter) and vga_fetch_addr.
package vga_pkg;

    localparam int H_DISPLAY        = 640;
    localparam int V_DISPLAY        = 480;
    localparam int FRAME_PIXELS_DEF = H_DISPLAY * V_DISPLAY;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/vga_fetch_addr.sv
// Display fetch pointer: loads 0 on frame_start, advances one pixel per fetch cycle,
// wraps from FRAME_PIXELS-1 back to 0.
module vga_fetch_addr
    import vga_pkg::*;
#(
    parameter int ADDR_W       = 19,
    parameter int FRAME_PIXELS = FRAME_PIXELS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] fetch_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    // frame_start acts in its own cycle so a coincident fetch reads address 0.
    assign fetch_addr = frame_start ? '0 : ptr_q;

    always_comb begin
        ptr_d = fetch_addr;
        if (fetch_en) begin
            ptr_d = (fetch_addr == LAST_ADDR) ? '0 : fetch_addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port pixel RAM arbiter: display fetch has absolute priority, writer uses blanking.
// Define VGA_ARB_STATS_EN to build the writer stall-cycle counter on stall_cnt.
module vga_mem_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 8,
    parameter int FRAME_PIXELS = FRAME_PIXELS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              disp_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic [15:0]       stall_cnt
);

    localparam logic [ADDR_W:0] FRAME_LIMIT = (ADDR_W + 1)'(FRAME_PIXELS);

    // state_d is the state owning the RAM this cycle; state_q is its copy one
    // cycle late, which lines up with the RAM read return.
    arb_state_e        state_d;
    arb_state_e        state_q;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] pix_hold_q;
    logic              addr_in_range;

    assign addr_in_range = ({1'b0, wr_addr} < FRAME_LIMIT);

    always_comb begin
        state_d = IDLE;
        if (!disp_n) begin
            state_d = FETCH;
        end else if (wr_req) begin
            state_d = WRITE;
        end
    end

    vga_fetch_addr #(
        .ADDR_W       (ADDR_W),
        .FRAME_PIXELS (FRAME_PIXELS)
    ) u_fetch_addr (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .fetch_en    (state_d == FETCH),
        .fetch_addr  (fetch_addr)
    );

    // NOTE: RAM-side outputs are decoded from this cycle's inputs, so they are
    // gated by rst_n to drop to 0 the moment reset asserts, abandoning any WRITE.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        wr_ack    = 1'b0;
        if (rst_n) begin
            case (state_d)
                FETCH: mem_addr = fetch_addr;
                WRITE: begin
                    mem_addr  = wr_addr;
                    mem_we    = addr_in_range;
                    mem_wdata = wr_data;
                    wr_ack    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pix_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            pix_hold_q <= pix_data;
        end
    end

    assign pix_valid = (state_q == FETCH);
    assign pix_data  = pix_valid ? mem_rdata : pix_hold_q;

`ifdef VGA_ARB_STATS_EN
    logic [15:0] stall_q;
    logic [15:0] stall_d;

    always_comb begin
        stall_d = stall_q;
        if (frame_start) begin
            stall_d = '0;
        end else if (wr_req && !wr_ack && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Scoreboard bench for vga_mem_arbiter with a registered-read RAM model (1024-pixel frame).
// Expected stall count follows VGA_ARB_STATS_EN.
module tb_vga_mem_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;
    localparam int FP     = 1024;
    localparam int LINE   = 640;

`ifdef VGA_ARB_STATS_EN
    localparam logic [15:0] EXP_STALL = 16'd640;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              we;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              frame_start;
    logic              disp_n;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic [15:0]       stall_cnt;

    vga_mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .FRAME_PIXELS (FP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .disp_n      (disp_n),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic logic [DATA_W-1:0] init_pix(input int i);
        return DATA_W'((i * 37 + 11) & 255);
    endfunction

    // RAM model: registered read, write on mem_we.
    logic              ram_init;
    logic [DATA_W-1:0] ram    [FP];
    logic [DATA_W-1:0] golden [FP];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < FP; i++) ram[i] <= init_pix(i);
        end else if (mem_we) begin
            ram[mem_addr[9:0]] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr[9:0]];
    end

    logic [ADDR_W-1:0] aq [$];
    logic [DATA_W-1:0] pq [$];
    wr_t               wq [$];
    logic              prev_fetch = 1'b0;

    // Monitor: samples on the falling edge, pops expectations as the DUT presents them.
    always @(negedge clk) begin
        logic              exp_pv;
        logic [ADDR_W-1:0] ea;
        wr_t               ew;
        exp_pv     = prev_fetch;
        prev_fetch = rst_n && !disp_n;
        check("pix_valid", 32'(pix_valid), 32'(exp_pv));
        if (pix_valid && exp_pv) begin
            if (pq.size() == 0) flag("pix_valid with no expected pixel");
            else check("pix_data", 32'(pix_data), 32'(pq.pop_front()));
        end
        if (rst_n && !disp_n) begin
            check("mem_we_visible", 32'(mem_we), 32'(0));
            check("wr_ack_visible", 32'(wr_ack), 32'(0));
            if (aq.size() == 0) begin
                flag("fetch with no expected address");
            end else begin
                ea = aq.pop_front();
                check("fetch_addr", 32'(mem_addr), 32'(ea));
                pq.push_back(golden[ea[9:0]]);
            end
        end
        if (wr_ack) begin
            if (wq.size() == 0) begin
                flag("unexpected wr_ack");
            end else begin
                ew = wq.pop_front();
                check("wr_mem_addr", 32'(mem_addr), 32'(ew.addr));
                check("wr_mem_we", 32'(mem_we), 32'(ew.we));
                check("wr_mem_wdata", 32'(mem_wdata), 32'(ew.data));
            end
        end
        if (rst_n && disp_n && !wr_req) check("mem_we_idle", 32'(mem_we), 32'(0));
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_line(input int n, input logic fs_first, input int start);
        for (int i = 0; i < n; i++) begin
            disp_n      = 1'b0;
            frame_start = fs_first && (i == 0);
            aq.push_back(ADDR_W'((start + i) % FP));
            @(posedge clk);
            #1;
        end
        disp_n      = 1'b1;
        frame_start = 1'b0;
    endtask

    task automatic write_one(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             output int cyc);
        logic got;
        wr_t  e;
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        e.addr  = a;
        e.data  = d;
        e.we    = (a < FP);
        wq.push_back(e);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 2000) begin
            @(negedge clk);
            got = wr_ack;
            cyc++;
            @(posedge clk);
            #1;
        end
        if (!got) flag("wr_ack timeout");
        else if (e.we) golden[a[9:0]] = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
        check({tag, "_mem_we"}, 32'(mem_we), 32'(0));
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
        check({tag, "_wr_ack"}, 32'(wr_ack), 32'(0));
        check({tag, "_pix_data"}, 32'(pix_data), 32'(0));
        check({tag, "_pix_valid"}, 32'(pix_valid), 32'(0));
        check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int c2;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        disp_n      = 1'b1;
        wr_req      = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        ram_init    = 1'b1;
        for (int i = 0; i < FP; i++) golden[i] = init_pix(i);

        repeat (2) @(posedge clk);
        #1;
        ram_init = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Blanking writes: three in range, then two out of range, all back-to-back.
        write_one(19'd5, 8'hA5, c);      check("wr0_cycles", 32'(c), 32'(1));
        write_one(19'd6, 8'hB6, c);      check("wr1_cycles", 32'(c), 32'(1));
        write_one(19'd7, 8'hC7, c);      check("wr2_cycles", 32'(c), 32'(1));
        write_one(19'd1024, 8'hFF, c);   check("wr_oor0_cycles", 32'(c), 32'(1));
        write_one(19'd307200, 8'hEE, c); check("wr_oor1_cycles", 32'(c), 32'(1));
        wr_req = 1'b0;
        idle(2);

        // Visible line starting with a coincident frame_start.
        drive_line(LINE, 1'b1, 0);
        idle(2);
        @(negedge clk);
        check("pix_hold_blank", 32'(pix_data), 32'(golden[LINE-1]));
        @(posedge clk);
        #1;

        // Writer held off across a full visible line.
        frame_start = 1'b1;
        idle(1);
        frame_start = 1'b0;
        fork
            drive_line(LINE, 1'b0, 0);
            write_one(19'd100, 8'h5A, c2);
        join
        wr_req = 1'b0;
        check("stalled_wr_cycles", 32'(c2), 32'(LINE + 1));
        @(negedge clk);
        check("stall_cnt_line", 32'(stall_cnt), 32'(EXP_STALL));
        @(posedge clk);
        #1;
        frame_start = 1'b1;
        idle(1);
        frame_start = 1'b0;
        @(negedge clk);
        check("stall_cnt_cleared", 32'(stall_cnt), 32'(0));
        @(posedge clk);
        #1;

        // Full frame plus two: pointer wraps from FP-1 to 0.
        drive_line(FP + 2, 1'b1, 0);
        idle(2);

        // Reset asserted in the middle of a WRITE cycle.
        wr_req  = 1'b1;
        wr_addr = 19'd200;
        wr_data = 8'h33;
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_write_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        write_one(19'd200, 8'h33, c);
        check("rerequest_cycles", 32'(c), 32'(1));
        wr_req = 1'b0;
        idle(1);

        // Reset cleared the pointer: fetch resumes at 0 without frame_start.
        drive_line(210, 1'b0, 0);
        idle(3);

        check("addr_queue_drained", 32'(aq.size()), 32'(0));
        check("pix_queue_drained", 32'(pq.size()), 32'(0));
        check("wr_queue_drained", 32'(wq.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_mem_arbiter.md
VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, pixel RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, pixel width.
REQ-003 SHALL have parameter FRAME_PIXELS, default 307200 (640x480), pixels per frame.
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port frame_start  in  1  one-cycle pulse, first cycle of a new frame.
REQ-007 SHALL have port disp_n  in  1  low = visible pixel this cycle, high = blanking.
REQ-008 SHALL have port wr_req  in  1  writer request, held until wr_ack.
REQ-009 SHALL have port wr_addr  in  ADDR_W  writer pixel address.
REQ-010 SHALL have port wr_data  in  DATA_W  writer pixel value.
REQ-011 SHALL have port wr_ack  out  1  one-cycle pulse, write committed this cycle.
REQ-012 SHALL have port mem_addr  out  ADDR_W  single-port RAM address.
REQ-013 SHALL have port mem_we  out  1  RAM write enable.
REQ-014 SHALL have port mem_wdata  out  DATA_W  RAM write data.
REQ-015 SHALL have port mem_rdata  in  DATA_W  RAM read data, valid one cycle after address.
REQ-016 SHALL have port pix_data  out  DATA_W  pixel to display path.
REQ-017 SHALL have port pix_valid  out  1  pix_data holds a fetched pixel.
REQ-018 SHALL have port stall_cnt  out  16  writer stall-cycle count (see Configuration).

Function
REQ-019 SHALL implement FSM with states IDLE, FETCH, WRITE.
REQ-020 SHALL enter FETCH from any state whenever disp_n is low; display fetch has absolute priority.
REQ-021 SHALL in FETCH drive mem_addr = fetch pointer, mem_we = 0, and increment pointer by 1 per cycle.
REQ-022 SHALL present mem_rdata on pix_data with pix_valid = 1 exactly one cycle after each FETCH cycle (latency 1).
REQ-023 SHALL wrap fetch pointer from FRAME_PIXELS-1 to 0.
REQ-024 SHALL load fetch pointer to 0 on frame_start; if frame_start and disp_n low coincide, address 0 is fetched that cycle.
REQ-025 SHALL, with disp_n high and wr_req high, enter WRITE for one cycle: mem_addr = wr_addr, mem_we = 1, mem_wdata = wr_data, wr_ack = 1.
REQ-026 SHALL return from WRITE to IDLE, or to FETCH if disp_n low; back-to-back writes take one WRITE cycle each with no idle gap.
REQ-027 SHALL never assert mem_we while disp_n is low; wr_req is held off (no wr_ack) for all visible cycles.
REQ-028 SHALL ignore wr_addr >= FRAME_PIXELS: ack it, suppress mem_we.
REQ-029 SHALL drive mem_we = 0 and hold pix_data in IDLE; pix_valid = 0 one cycle after any non-FETCH cycle.

Reset
REQ-030 SHALL on rst_n low, immediately: state IDLE, fetch pointer 0, mem_addr 0, mem_we 0, mem_wdata 0, wr_ack 0, pix_data 0, pix_valid 0, stall_cnt 0.
REQ-031 SHALL abandon an in-flight WRITE on reset with no wr_ack; writer re-requests.

Configuration
REQ-032 SHALL, with VGA_ARB_STATS_EN defined, count cycles where wr_req is high and wr_ack is low on stall_cnt, saturating at 16'hFFFF, cleared on frame_start.
REQ-033 SHALL, without VGA_ARB_STATS_EN, tie stall_cnt to 0 and omit the counter logic.

Structure
REQ-034 SHALL take FRAME_PIXELS default, H_DISPLAY/V_DISPLAY and the FSM state encoding from shared package vga_pkg.
REQ-035 SHALL place the fetch pointer (load, increment, wrap) in sub-module vga_fetch_addr.

Verification
REQ-036 Reset mid-WRITE (rst_n low while mem_we = 1) -> all outputs 0 same cycle, no wr_ack.
REQ-037 disp_n low 640 cycles after frame_start -> mem_addr 0..639, pix_valid high cycles 1..640, pix_data = RAM contents.
REQ-038 wr_req held high across visible line -> no mem_we during disp_n low; wr_ack first cycle after disp_n rises; stall_cnt = 640 with macro, 0 without.
REQ-039 Fetch pointer at 307199 with disp_n low -> next mem_addr 0.
REQ-040 Three queued writes during blanking -> wr_ack on three consecutive cycles, addresses in order; wr_addr 307200 acked with mem_we 0.
